// File: rtl/mix_columns_iter.sv
// Iterative AES MixColumns engine: COLS_PER_CYCLE columns per clock, valid/ready on both sides.
// Define MIXCOL_INVERSE_EN to build the InvMixColumns datapath and honour INV_MODE.
module mix_columns_iter #(
    parameter int COLS_PER_CYCLE = 1
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         IN_VALID,
    output logic         IN_READY,
    input  logic [127:0] IN_DATA,
    input  logic         INV_MODE,
    output logic         OUT_VALID,
    input  logic         OUT_READY,
    output logic [127:0] MIXED_DATA,
    output logic         BUSY
);

    generate
        if (COLS_PER_CYCLE != 1 && COLS_PER_CYCLE != 2 && COLS_PER_CYCLE != 4) begin : g_cfg_err
            $error("mix_columns_iter: COLS_PER_CYCLE must be 1, 2 or 4");
        end
    endgenerate

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_BUSY = 2'd1,
        S_DONE = 2'd2
    } state_t;

    localparam logic [1:0] COL_STEP  = 2'(COLS_PER_CYCLE);
    localparam logic [2:0] COL_STEP3 = 3'(COLS_PER_CYCLE);

    function automatic logic [7:0] xtime(input logic [7:0] a);
        return {a[6:0], 1'b0} ^ (a[7] ? 8'h1B : 8'h00);
    endfunction

    function automatic logic [7:0] row_fwd(input logic [7:0] a0, input logic [7:0] a1,
                                           input logic [7:0] a2, input logic [7:0] a3);
        return xtime(a0) ^ xtime(a1) ^ a1 ^ a2 ^ a3;
    endfunction

    function automatic logic [31:0] fwd_col(input logic [31:0] c);
        return {row_fwd(c[31:24], c[23:16], c[15:8],  c[7:0]),
                row_fwd(c[23:16], c[15:8],  c[7:0],   c[31:24]),
                row_fwd(c[15:8],  c[7:0],   c[31:24], c[23:16]),
                row_fwd(c[7:0],   c[31:24], c[23:16], c[15:8])};
    endfunction

`ifdef MIXCOL_INVERSE_EN
    // 0E/0B/0D/09 products built from the shared x2/x4/x8 chain of each byte.
    function automatic logic [7:0] row_inv(input logic [7:0] a0, input logic [7:0] a1,
                                           input logic [7:0] a2, input logic [7:0] a3);
        logic [7:0] p0, p1, p2, p3;
        p0 = xtime(xtime(xtime(a0))) ^ xtime(xtime(a0)) ^ xtime(a0);
        p1 = xtime(xtime(xtime(a1))) ^ xtime(a1) ^ a1;
        p2 = xtime(xtime(xtime(a2))) ^ xtime(xtime(a2)) ^ a2;
        p3 = xtime(xtime(xtime(a3))) ^ a3;
        return p0 ^ p1 ^ p2 ^ p3;
    endfunction

    function automatic logic [31:0] inv_col(input logic [31:0] c);
        return {row_inv(c[31:24], c[23:16], c[15:8],  c[7:0]),
                row_inv(c[23:16], c[15:8],  c[7:0],   c[31:24]),
                row_inv(c[15:8],  c[7:0],   c[31:24], c[23:16]),
                row_inv(c[7:0],   c[31:24], c[23:16], c[15:8])};
    endfunction
`endif

    state_t           state_reg, state_next;
    logic [0:3][31:0] work_reg, work_next;   // index 0 is column 0 (MSB word)
    logic [1:0]       col_idx_reg, col_idx_next;
    logic             ready_en_reg;
    logic             accept;
    logic             load;
    logic             last_group;

    logic [1:0]  col_sel   [COLS_PER_CYCLE];
    logic [31:0] mixed_col [COLS_PER_CYCLE];

`ifdef MIXCOL_INVERSE_EN
    logic mode_reg;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            mode_reg <= 1'b0;
        end else if (load) begin
            mode_reg <= INV_MODE;
        end
    end
`else
    logic unused_inv_mode;
    assign unused_inv_mode = INV_MODE;
`endif

    generate
        for (genvar gi = 0; gi < COLS_PER_CYCLE; gi++) begin : g_col
            assign col_sel[gi] = col_idx_reg + 2'(gi);
`ifdef MIXCOL_INVERSE_EN
            assign mixed_col[gi] = mode_reg ? inv_col(work_reg[col_sel[gi]])
                                            : fwd_col(work_reg[col_sel[gi]]);
`else
            assign mixed_col[gi] = fwd_col(work_reg[col_sel[gi]]);
`endif
        end
    endgenerate

    // ready_en_reg keeps IN_READY low through reset and the first edge after it.
    assign IN_READY   = ready_en_reg &
                        ((state_reg == S_IDLE) || ((state_reg == S_DONE) && OUT_READY));
    assign OUT_VALID  = (state_reg == S_DONE);
    assign BUSY       = (state_reg == S_BUSY);
    assign MIXED_DATA = work_reg;
    assign accept     = IN_VALID & IN_READY;
    assign last_group = (({1'b0, col_idx_reg} + COL_STEP3) == 3'd4);

    always_comb begin
        state_next   = state_reg;
        work_next    = work_reg;
        col_idx_next = col_idx_reg;
        load         = 1'b0;
        case (state_reg)
            S_IDLE: begin
                if (accept) begin
                    load       = 1'b1;
                    state_next = S_BUSY;
                end
            end
            S_BUSY: begin
                for (int i = 0; i < COLS_PER_CYCLE; i++) begin
                    work_next[col_sel[i]] = mixed_col[i];
                end
                col_idx_next = col_idx_reg + COL_STEP;
                if (last_group) begin
                    state_next = S_DONE;
                end
            end
            S_DONE: begin
                if (OUT_READY) begin
                    if (accept) begin
                        load       = 1'b1;
                        state_next = S_BUSY;
                    end else begin
                        state_next = S_IDLE;
                    end
                end
            end
            default: state_next = S_IDLE;
        endcase
        if (load) begin
            work_next    = IN_DATA;
            col_idx_next = 2'd0;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_reg    <= S_IDLE;
            work_reg     <= '0;
            col_idx_reg  <= 2'd0;
            ready_en_reg <= 1'b0;
        end else begin
            state_reg    <= state_next;
            work_reg     <= work_next;
            col_idx_reg  <= col_idx_next;
            ready_en_reg <= 1'b1;
        end
    end

endmodule

// File: tb/tb_mix_columns_iter.sv
// Bench for mix_columns_iter: three instances (1, 2 and 4 columns per cycle) with a
// shared scoreboard monitor and directed steps; honours MIXCOL_INVERSE_EN like the RTL.
module tb_mix_columns_iter;

    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    logic         in_valid   [3];
    logic         in_ready   [3];
    logic [127:0] in_data    [3];
    logic         inv_mode   [3];
    logic         out_valid  [3];
    logic         out_ready  [3];
    logic [127:0] mixed_data [3];
    logic         busy       [3];

    localparam int LAT [3] = '{4, 2, 1};
`ifdef MIXCOL_INVERSE_EN
    localparam bit INV_EN = 1'b1;
`else
    localparam bit INV_EN = 1'b0;
`endif

    localparam logic [127:0] V_FWD_IN  = 128'hdb135345_f20a225c_01010101_c6c6c6c6;
    localparam logic [127:0] V_FWD_OUT = 128'h8e4da1bc_9fdc589d_01010101_c6c6c6c6;
    localparam logic [127:0] V_BP_IN   = 128'hd4d4d4d5_2d26314c_00000000_ffffffff;
    localparam logic [127:0] V_BP_OUT  = 128'hd5d5d7d6_4d7ebdf8_00000000_ffffffff;

    generate
        for (genvar gi = 0; gi < 3; gi++) begin : g_dut
            mix_columns_iter #(.COLS_PER_CYCLE(gi == 0 ? 1 : (gi == 1 ? 2 : 4))) dut (
                .clk        (clk),
                .rst        (rst),
                .IN_VALID   (in_valid[gi]),
                .IN_READY   (in_ready[gi]),
                .IN_DATA    (in_data[gi]),
                .INV_MODE   (inv_mode[gi]),
                .OUT_VALID  (out_valid[gi]),
                .OUT_READY  (out_ready[gi]),
                .MIXED_DATA (mixed_data[gi]),
                .BUSY       (busy[gi])
            );
        end
    endgenerate

    int checks = 0;
    int errors = 0;
    int cyc    = 0;

    logic [127:0] exp_q [3][$];
    int           acc_q [3][$];
    bit           prev_valid [3];
    bit           prev_hs    [3];

    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string tag, input logic [127:0] obs, input logic [127:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic check_int(input string tag, input int obs, input int exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
        end
    endtask

    // Reference: generic shift-and-add GF(2^8) multiply against the coefficient rows.
    function automatic logic [7:0] gmul(input logic [7:0] a, input logic [7:0] b);
        logic [7:0] p = 8'h00;
        logic [7:0] x = a;
        for (int i = 0; i < 8; i++) begin
            if (b[i]) p ^= x;
            x = {x[6:0], 1'b0} ^ (x[7] ? 8'h1b : 8'h00);
        end
        return p;
    endfunction

    function automatic logic [127:0] model(input logic [127:0] s, input logic inv);
        logic [7:0]   coef [4];
        logic [127:0] r;
        logic [7:0]   acc;
        if (inv) coef = '{8'h0e, 8'h0b, 8'h0d, 8'h09};
        else     coef = '{8'h02, 8'h03, 8'h01, 8'h01};
        r = '0;
        for (int c = 0; c < 4; c++) begin
            for (int rr = 0; rr < 4; rr++) begin
                acc = 8'h00;
                for (int k = 0; k < 4; k++)
                    acc ^= gmul(s[127 - 32*c - 8*((rr + k) % 4) -: 8], coef[k]);
                r[127 - 32*c - 8*rr -: 8] = acc;
            end
        end
        return r;
    endfunction

    // Scoreboard monitor, sampled on the falling edge.
    always @(negedge clk) begin
        if (rst) begin
            for (int k = 0; k < 3; k++) begin
                exp_q[k].delete();
                acc_q[k].delete();
                prev_valid[k] = 1'b0;
                prev_hs[k]    = 1'b0;
            end
        end else begin
            for (int k = 0; k < 3; k++) begin
                if (out_valid[k] && (!prev_valid[k] || prev_hs[k])) begin
                    check_int($sformatf("expected_result[%0d]", k), int'(exp_q[k].size() > 0), 1);
                    if (acc_q[k].size() > 0)
                        check_int($sformatf("latency[%0d]", k), cyc - acc_q[k].pop_front(), LAT[k]);
                end
                if (out_valid[k] && out_ready[k] && exp_q[k].size() > 0) begin
                    $display("inst %0d result %h", k, mixed_data[k]);
                    check($sformatf("scoreboard[%0d]", k), mixed_data[k], exp_q[k].pop_front());
                end
                if (in_valid[k] && in_ready[k]) begin
                    exp_q[k].push_back(model(in_data[k], inv_mode[k] & INV_EN));
                    acc_q[k].push_back(cyc + 1);
                end
                prev_valid[k] = out_valid[k];
                prev_hs[k]    = out_valid[k] & out_ready[k];
            end
        end
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic send(input int k, input logic [127:0] d, input logic inv);
        int waited = 0;
        in_valid[k] = 1'b1;
        in_data[k]  = d;
        inv_mode[k] = inv;
        while (!in_ready[k] && waited < 20) begin
            step();
            waited++;
        end
        check_int($sformatf("send_ready[%0d]", k), int'(in_ready[k]), 1);
        step();
        in_valid[k] = 1'b0;
    endtask

    task automatic wait_valid(input int k, input int budget);
        int waited = 0;
        while (!out_valid[k] && waited < budget) begin
            step();
            waited++;
        end
        check_int($sformatf("wait_valid[%0d]", k), int'(out_valid[k]), 1);
    endtask

    task automatic release_out(input int k);
        out_ready[k] = 1'b1;
        step();
        out_ready[k] = 1'b0;
    endtask

    task automatic check_zero(input int k, input string tag);
        check_int({tag, "_in_ready"},  int'(in_ready[k]),  0);
        check_int({tag, "_out_valid"}, int'(out_valid[k]), 0);
        check_int({tag, "_busy"},      int'(busy[k]),      0);
        check({tag, "_mixed"}, mixed_data[k], 128'h0);
    endtask

    function automatic logic [127:0] rand_state();
        return {$urandom, $urandom, $urandom, $urandom};
    endfunction

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [127:0] s;
        int           waited;
        rst = 1'b1;
        for (int k = 0; k < 3; k++) begin
            in_valid[k]  = 1'b0;
            in_data[k]   = '0;
            inv_mode[k]  = 1'b0;
            out_ready[k] = 1'b0;
        end
        step();
        step();
        for (int k = 0; k < 3; k++) check_zero(k, $sformatf("reset[%0d]", k));

        rst = 1'b0;
        #1;
        check_int("ready_before_edge", int'(in_ready[0]), 0);
        step();
        for (int k = 0; k < 3; k++) check_int($sformatf("ready_after_reset[%0d]", k), int'(in_ready[k]), 1);

        // forward vector, one column per cycle
        send(0, V_FWD_IN, 1'b0);
        wait_valid(0, 20);
        check("fwd_vector", mixed_data[0], V_FWD_OUT);
        release_out(0);

        // inverse vector, two columns per cycle
        send(1, V_FWD_OUT, 1'b1);
        wait_valid(1, 20);
        check("inv_vector", mixed_data[1], INV_EN ? V_FWD_IN : model(V_FWD_OUT, 1'b0));
        release_out(1);

        // backpressure, four columns per cycle
        send(2, V_BP_IN, 1'b0);
        wait_valid(2, 20);
        in_valid[2] = 1'b1;
        in_data[2]  = rand_state();
        for (int i = 0; i < 10; i++) begin
            check_int("bp_out_valid", int'(out_valid[2]), 1);
            check("bp_hold", mixed_data[2], V_BP_OUT);
            check_int("bp_in_ready", int'(in_ready[2]), 0);
            step();
        end
        in_valid[2] = 1'b0;
        release_out(2);

        // inputs toggled while busy must be ignored
        s = rand_state();
        send(0, s, 1'b0);
        for (int i = 0; i < 3; i++) begin
            check_int("ign_busy", int'(busy[0]), 1);
            check_int("ign_in_ready", int'(in_ready[0]), 0);
            in_valid[0] = ~in_valid[0];
            in_data[0]  = rand_state();
            step();
        end
        in_valid[0] = 1'b0;
        wait_valid(0, 20);
        check("ign_result", mixed_data[0], model(s, 1'b0));
        release_out(0);

        // back-to-back streams
        for (int k = 0; k < 3; k++) begin
            out_ready[k] = 1'b1;
            for (int i = 0; i < 8; i++) begin
                in_valid[k] = 1'b1;
                in_data[k]  = rand_state();
                inv_mode[k] = 1'($urandom_range(0, 1));
                waited = 0;
                while (!in_ready[k] && waited < 20) begin
                    step();
                    waited++;
                end
                check_int($sformatf("b2b_gap[%0d]", k), waited, (i == 0) ? 0 : LAT[k]);
                step();
            end
            in_valid[k] = 1'b0;
            inv_mode[k] = 1'b0;
            wait_valid(k, 20);
            step();
            out_ready[k] = 1'b0;
        end

        // reset two cycles after an accept
        send(0, rand_state(), 1'b0);
        step();
        rst = 1'b1;
        #1;
        check_zero(0, "rst_busy");
        step();
        step();
        check_zero(0, "rst_hold");
        rst = 1'b0;
        for (int i = 0; i < 6; i++) begin
            check_int("rst_no_valid", int'(out_valid[0]), 0);
            step();
        end
        send(0, V_FWD_IN, 1'b0);
        wait_valid(0, 20);
        check("post_reset_vector", mixed_data[0], V_FWD_OUT);
        release_out(0);

        step();
        step();
        for (int k = 0; k < 3; k++) check_int($sformatf("drained[%0d]", k), exp_q[k].size(), 0);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
